// File: rtl/gate_array_pipe_pkg.sv
// Shared opcode and reduction-bit definitions for the gate array pipeline.
package gate_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  // Bit positions of the reduction summary inside out_y.
  localparam int RED_ANY = 0;
  localparam int RED_ALL = 1;
  localparam int RED_PAR = 2;

endpackage

// File: rtl/gate_array_pipe_if.sv
// Operand/result streaming bundle; master drives operands and consumes results.
interface gate_array_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  import gate_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [OP_W-1:0]      in_op;
  logic                 in_reduce;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_y;
  logic                 out_zero;
  logic [CNT_W-1:0]     out_count;

  modport master (
    output in_valid, in_a, in_b, in_op, in_reduce, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_reduce, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_count
  );

endinterface

// File: rtl/gate_array_pipe_core.sv
// Combinational bitwise gate function with optional any/all/parity reduction.
module gate_array_core
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             reduce_i,
  output logic [WIDTH-1:0] y_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] r;

  always_comb begin
    r = '0;
    unique case (op_i)
      OP_AND:  r = a_i & b_i;
      OP_OR:   r = a_i | b_i;
      OP_NOT:  r = ~a_i;
      OP_NAND: r = ~(a_i & b_i);
      OP_NOR:  r = ~(a_i | b_i);
      OP_XOR:  r = a_i ^ b_i;
      OP_XNOR: r = ~(a_i ^ b_i);
      OP_PASS: r = a_i;
      default: r = '0;
    endcase
  end

  always_comb begin
    y_o = r;
    if (reduce_i) begin
      y_o          = '0;
      y_o[RED_ANY] = |r;
      y_o[RED_ALL] = &r;
      y_o[RED_PAR] = ^r;
    end
  end

  assign zero_o = ~|y_o;

endmodule

// File: rtl/gate_array_pipe.sv
// Two-stage valid/ready gate array: S1 holds operands, S2 holds result; 2-cycle latency,
// full-rate throughput, ready chain is combinational from out_ready so no bubbles.
module gate_array_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  gate_array_pipe_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic             reduce;
  } s1_t;

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_ready;
  logic             s2_ready;
  logic [WIDTH-1:0] core_y;
  logic             core_zero;

  assign s2_ready     = ~s2_valid_q | bus.out_ready;
  assign s1_ready     = ~s1_valid_q | s2_ready;
  assign bus.in_ready = s1_ready;

  gate_array_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i      (s1_q.a),
    .b_i      (s1_q.b),
    .op_i     (s1_q.op),
    .reduce_i (s1_q.reduce),
    .y_o      (core_y),
    .zero_o   (core_zero)
  );

  // A stage that is draining this cycle may be refilled in the same cycle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    zero_d     = zero_q;
    cnt_d      = cnt_q;

    if (s1_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d.a      = bus.in_a;
        s1_d.b      = bus.in_b;
        s1_d.op     = bus.in_op;
        s1_d.reduce = bus.in_reduce;
      end
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d    = core_y;
        zero_d = core_zero;
      end
    end

    if (s2_valid_q && bus.out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      zero_q     <= 1'b1;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      zero_q     <= zero_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_y     = y_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_count = cnt_q;

endmodule
